// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: small word FIFO plus a shifter.
// Define SERIALIZER_MSB_FIRST_EN to shift each word MSB first instead of LSB first.
module seq_bit_serializer #(
  parameter int   WORD_BITS = 8,
  parameter int   DEPTH     = 4,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                   clock0,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [WORD_BITS-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   x,
  output logic                   x_valid,
  output logic                   word_start,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WORD_BITS);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [WORD_BITS-1:0] shreg;

  logic                 push;
  logic                 pop;
  logic                 word_done;
  logic [WORD_BITS-1:0] head;
  logic                 first_bit;
  logic                 next_bit;
  logic [WORD_BITS-1:0] load_rest;
  logic [WORD_BITS-1:0] shifted;

  assign in_ready  = (level != FULL) && !flush;
  assign push      = in_valid && in_ready;
  assign word_done = (state == IDLE) || (count == LAST);
  // Only registered occupancy gates the pop, so a fresh push never bypasses into the shifter.
  assign pop       = !flush && word_done && (level != '0);
  assign head      = mem[rd_ptr];

`ifdef SERIALIZER_MSB_FIRST_EN
  assign first_bit = head[WORD_BITS-1];
  assign load_rest = head << 1;
  assign next_bit  = shreg[WORD_BITS-1];
  assign shifted   = shreg << 1;
`else
  assign first_bit = head[0];
  assign load_rest = head >> 1;
  assign next_bit  = shreg[0];
  assign shifted   = shreg >> 1;
`endif

  always_ff @(posedge clock0) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock0 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      count      <= '0;
      shreg      <= '0;
      x          <= IDLE_BIT;
      x_valid    <= 1'b0;
      word_start <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      count      <= '0;
      x          <= IDLE_BIT;
      x_valid    <= 1'b0;
      word_start <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;

      underflow <= 1'b0;
      if (pop) begin
        state      <= SHIFT;
        shreg      <= load_rest;
        x          <= first_bit;
        x_valid    <= 1'b1;
        word_start <= 1'b1;
        count      <= '0;
      end else if (state == SHIFT && count != LAST) begin
        count      <= count + 1'b1;
        shreg      <= shifted;
        x          <= next_bit;
        word_start <= 1'b0;
      end else if (state == SHIFT) begin
        // Last bit went out and nothing is queued: the detector now sees filler.
        state      <= IDLE;
        x          <= IDLE_BIT;
        x_valid    <= 1'b0;
        word_start <= 1'b0;
        underflow  <= 1'b1;
      end else begin
        x          <= IDLE_BIT;
        x_valid    <= 1'b0;
        word_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: directed scenarios plus random traffic
// compared against a queue-based model of the word stream.
module tb_seq_bit_serializer;

  localparam int WB = 8;
  localparam int DP = 4;

  logic          clock0 = 1'b0;
  logic          reset;
  logic          flush;
  logic [WB-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          x;
  logic          x_valid;
  logic          word_start;
  logic          underflow;
  logic [2:0]    level;

  int checks = 0;
  int errors = 0;

  // Model: queued words plus the bits of the current word not yet shown on x.
  logic [WB-1:0] mq[$];
  int            rem[$];
  logic          mx, mxv, mws, muf;

  seq_bit_serializer #(.WORD_BITS(WB), .DEPTH(DP), .IDLE_BIT(1'b0)) dut (
    .clock0(clock0), .reset(reset), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .x_valid(x_valid),
    .word_start(word_start), .underflow(underflow), .level(level)
  );

  always #5 clock0 = ~clock0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    rem.delete();
    mx = 1'b0; mxv = 1'b0; mws = 1'b0; muf = 1'b0;
  endtask

  task automatic modelEdge();
    int pre;
    bit do_push;
    logic [WB-1:0] w;
    pre = mq.size();
    do_push = in_valid && !flush && (pre < DP);
    if (flush) begin
      modelReset();
    end else begin
      if (pre > 0 && rem.size() == 0) begin
        w = mq.pop_front();
        for (int i = 0; i < WB; i++) begin
`ifdef SERIALIZER_MSB_FIRST_EN
          rem.push_back(int'(w[WB-1-i]));
`else
          rem.push_back(int'(w[i]));
`endif
        end
        mx = 1'(rem.pop_front()); mxv = 1'b1; mws = 1'b1; muf = 1'b0;
      end else if (rem.size() > 0) begin
        mx = 1'(rem.pop_front()); mws = 1'b0; muf = 1'b0;
      end else begin
        muf = mxv; mxv = 1'b0; mx = 1'b0; mws = 1'b0;
      end
      if (do_push)
        mq.push_back(in_data);
    end
  endtask

  task automatic compareAll();
    checkOutput("x", 32'(x), 32'(mx));
    checkOutput("x_valid", 32'(x_valid), 32'(mxv));
    checkOutput("word_start", 32'(word_start), 32'(mws));
    checkOutput("underflow", 32'(underflow), 32'(muf));
    checkOutput("level", 32'(level), 32'(mq.size()));
    checkOutput("in_ready", 32'(in_ready), 32'((mq.size() < DP) && !flush));
  endtask

  // One clock edge with the currently driven inputs, then compare on the falling edge.
  task automatic applyStimulus();
    @(posedge clock0);
    modelEdge();
    @(negedge clock0);
    compareAll();
  endtask

  initial begin
    logic [WB-1:0] pat;
    logic [WB-1:0] words [6];
    int k;
    int n;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    modelReset();
    repeat (2) @(negedge clock0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_x_valid", 32'(x_valid), 32'd0);
    reset = 1'b0;
    compareAll();

    $display("[TB] idle after reset");
    repeat (5) applyStimulus();

    $display("[TB] single push of 0xB4");
    pat = 8'hB4;
    in_data = pat; in_valid = 1'b1;
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("single_level", 32'(level), 32'd1);
    for (int i = 0; i < WB; i++) begin
      applyStimulus();
`ifdef SERIALIZER_MSB_FIRST_EN
      checkOutput("single_bit", 32'(x), 32'(pat[WB-1-i]));
`else
      checkOutput("single_bit", 32'(x), 32'(pat[i]));
`endif
      checkOutput("single_word_start", 32'(word_start), 32'(i == 0));
    end
    applyStimulus();
    checkOutput("single_end_valid", 32'(x_valid), 32'd0);
    checkOutput("single_underflow", 32'(underflow), 32'd1);
    applyStimulus();
    checkOutput("single_underflow_clear", 32'(underflow), 32'd0);

    $display("[TB] continuous stream of six words");
    for (int i = 0; i < 6; i++) words[i] = WB'($urandom);
    k = 0; n = 0;
    in_valid = 1'b1; in_data = words[0];
    while (n < 60) begin
      automatic bit accepted = in_valid && in_ready;
      applyStimulus();
      if (n == 4) begin
        checkOutput("stream_full_level", 32'(level), 32'd4);
        checkOutput("stream_full_ready", 32'(in_ready), 32'd0);
      end
      if (n == 9) checkOutput("stream_pop_level", 32'(level), 32'd3);
      if (n == 10) checkOutput("stream_w5_accept", 32'(k), 32'd5);
      if (n >= 1 && n <= 48) checkOutput("stream_no_gap", 32'(x_valid), 32'd1);
      if (n >= 1 && n <= 48) checkOutput("stream_word_start", 32'(word_start), 32'(((n - 1) % WB) == 0));
      if (accepted) k++;
      if (k < 6) in_data = words[k];
      else in_valid = 1'b0;
      n++;
    end

    $display("[TB] flush mid-word");
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = WB'($urandom);
      applyStimulus();
    end
    in_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("pre_flush_level", 32'(level), 32'd2);
    flush = 1'b1; in_valid = 1'b1; in_data = WB'($urandom);
    applyStimulus();
    checkOutput("flush_level", 32'(level), 32'd0);
    checkOutput("flush_x_valid", 32'(x_valid), 32'd0);
    checkOutput("flush_underflow", 32'(underflow), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    applyStimulus();
    checkOutput("post_flush_underflow", 32'(underflow), 32'd0);
    in_valid = 1'b1; in_data = WB'($urandom);
    applyStimulus();
    in_valid = 1'b0;
    repeat (11) applyStimulus();

    $display("[TB] asynchronous reset mid-word");
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = WB'($urandom);
      applyStimulus();
    end
    in_valid = 1'b0;
    repeat (2) applyStimulus();
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset_x_valid", 32'(x_valid), 32'd0);
    checkOutput("async_reset_x", 32'(x), 32'd0);
    checkOutput("async_reset_level", 32'(level), 32'd0);
    checkOutput("async_reset_word_start", 32'(word_start), 32'd0);
    @(negedge clock0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("no_residual_bits", 32'(x_valid), 32'd0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 3) != 0;
      in_data  = WB'($urandom);
      flush    = ($urandom % 40) == 0;
      applyStimulus();
    end
    flush = 1'b0; in_valid = 1'b0;
    repeat (45) applyStimulus();
    checkOutput("drained_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
